// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM init engine: FSM states, LFSR taps, default seed.
// Pure declarations; no latency or backpressure of its own.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StSeed    = 3'd1,
      StWrite   = 3'd2,
      StDone    = 3'd3,
      StWaitLow = 3'd4
   } init_state_e;

   // Fibonacci taps 64,63,61,60 as a bit mask over state bits [63:0]
   localparam logic [63:0] LfsrTaps        = 64'hD800_0000_0000_0000;
   localparam logic [63:0] InitDefaultSeed = 64'h5EED_C0DE_0BAD_F00D;

   function automatic logic [63:0] lfsr_next(input logic [63:0] s);
      return {s[62:0], ^(s & LfsrTaps)};
   endfunction

endpackage

// File: rtl/sram_init_lfsr.sv
// 64-bit Fibonacci LFSR with synchronous seed load (zero seed replaced by DefaultSeed).
// State updates one cycle after load_i/step_i; load_i wins over step_i; no backpressure.
module sram_init_lfsr
   import sram_ctrl_pkg::*;
#(
   parameter logic [63:0] DefaultSeed = InitDefaultSeed
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [63:0] seed_i,
   input  logic        step_i,
   output logic [63:0] state_o
);

   logic [63:0] state_q;

   // An all-zero state would lock up the LFSR, so it is never loaded
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= DefaultSeed;
      end else if (load_i) begin
         state_q <= (seed_i == 64'd0) ? DefaultSeed : seed_i;
      end else if (step_i) begin
         state_q <= lfsr_next(state_q);
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/sram_init_engine.sv
// Writes LFSR data to every SRAM word on request, then pulses init_ack_o once; ack lands Depth+2 cycles after accept with gnt tied high.
// Backpressure: each write is held with stable addr/data until mem_gnt_i; abort_i returns to Idle on the next edge.
module sram_init_engine
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned Depth       = 4096,
   parameter int unsigned Width       = 39,
   parameter int unsigned SeedWidth   = 64,
   parameter logic [63:0] DefaultSeed = InitDefaultSeed,
   localparam int unsigned AddrWidth  = $clog2(Depth)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 init_req_i,
   input  logic [SeedWidth-1:0] init_seed_i,
   output logic                 init_ack_o,
   input  logic                 abort_i,
   output logic                 busy_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [Width-1:0]     mem_wdata_o,
   input  logic                 mem_gnt_i
);

   if (Width > 64) begin : g_chk_width
      $error("sram_init_engine: Width must be <= 64");
   end
   if (SeedWidth < Width) begin : g_chk_seed_min
      $error("sram_init_engine: SeedWidth must be >= Width");
   end
   if (SeedWidth > 64) begin : g_chk_seed_max
      $error("sram_init_engine: SeedWidth must be <= 64");
   end
   if (Depth < 2) begin : g_chk_depth
      $error("sram_init_engine: Depth must be >= 2");
   end

   localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

   init_state_e          state_q, state_d;
   logic [AddrWidth-1:0] addr_q;
   logic                 addr_clr, addr_inc;
   logic                 lfsr_load, lfsr_step;
   logic [63:0]          lfsr_seed, lfsr_state, seed_ext;
   logic                 unused_lfsr;

   assign seed_ext  = 64'(init_seed_i);
   // Abort reloads the default seed so the LFSR is left in its reset state
   assign lfsr_seed = abort_i ? DefaultSeed : seed_ext;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      addr_clr  = 1'b0;
      addr_inc  = 1'b0;
      if (abort_i) begin
         state_d   = StIdle;
         lfsr_load = 1'b1;
         addr_clr  = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (init_req_i) begin
                  state_d   = StSeed;
                  lfsr_load = 1'b1;
               end
            end
            StSeed: begin
               addr_clr  = 1'b1;
               lfsr_step = 1'b1;
               state_d   = StWrite;
            end
            StWrite: begin
               if (mem_gnt_i) begin
                  if (addr_q == LastAddr) begin
                     state_d = StDone;
                  end else begin
                     addr_inc  = 1'b1;
                     lfsr_step = 1'b1;
                  end
               end
            end
            StDone: begin
               state_d = StWaitLow;
            end
            StWaitLow: begin
               if (!init_req_i) begin
                  state_d = StIdle;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q <= '0;
      end else if (addr_clr) begin
         addr_q <= '0;
      end else if (addr_inc) begin
         addr_q <= addr_q + AddrWidth'(1);
      end
   end

   sram_init_lfsr #(
      .DefaultSeed (DefaultSeed)
   ) u_lfsr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (lfsr_load),
      .seed_i  (lfsr_seed),
      .step_i  (lfsr_step),
      .state_o (lfsr_state)
   );

   assign unused_lfsr = ^lfsr_state;

   // Outputs decode registered state only; data/address are zeroed outside Write
   assign busy_o      = (state_q == StSeed) || (state_q == StWrite);
   assign mem_req_o   = (state_q == StWrite);
   assign mem_we_o    = mem_req_o;
   assign mem_addr_o  = mem_req_o ? addr_q : '0;
   assign mem_wdata_o = mem_req_o ? lfsr_state[Width-1:0] : '0;
   assign init_ack_o  = (state_q == StDone);

endmodule

// File: tb/tb_sram_init_engine.sv
// Randomised bench for sram_init_engine (Depth=16) against a sequence-level model of the init walk.
module tb_sram_init_engine;

   localparam int          DEPTH    = 16;
   localparam int          WIDTH    = 39;
   localparam int          AW       = 4;
   localparam logic [63:0] DEF_SEED = 64'h5EED_C0DE_0BAD_F00D;
   localparam logic [63:0] DMASK    = (64'd1 << WIDTH) - 64'd1;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          init_req = 1'b0;
   logic [63:0]   init_seed = '0;
   logic          ack;
   logic          abort = 1'b0;
   logic          busy;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic          mem_gnt = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   sram_init_engine #(
      .Depth (DEPTH)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .init_req_i  (init_req),
      .init_seed_i (init_seed),
      .init_ack_o  (ack),
      .abort_i     (abort),
      .busy_o      (busy),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_gnt_i   (mem_gnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Fibonacci step: XOR of tap positions 64,63,61,60 shifted into bit 0
   function automatic logic [63:0] ref_step(input logic [63:0] s);
      int       taps[4] = '{64, 63, 61, 60};
      logic     fb = 1'b0;
      foreach (taps[k]) fb = fb ^ s[taps[k]-1];
      return {s[62:0], fb};
   endfunction

   // gmode: 1 = grant every Write cycle, 3 = every third Write cycle, 0 = random.
   // abort_wr: write index on whose grant abort is raised (-1 none).
   // ack_edge counts rising edges from the accept edge to the edge that captures ack.
   task automatic run_init(input logic [63:0] seed, input int gmode, input int abort_wr,
                           input int hold_cyc, output int n_wr, output int n_ack,
                           output int ack_edge, output logic [63:0] first_dat);
      logic [63:0]      m;
      logic [AW-1:0]    p_addr;
      logic [WIDTH-1:0] p_data;
      logic             p_req, p_gnt, g;
      int               cyc, req_cyc, post, ab_post;
      bit               ab_done, fin;
      m = ref_step((seed == 64'd0) ? DEF_SEED : seed);
      n_wr = 0; n_ack = 0; ack_edge = -1; first_dat = '0;
      cyc = 0; req_cyc = 0; post = 0; ab_post = 0; ab_done = 0; fin = 0;
      p_req = 0; p_gnt = 0; p_addr = '0; p_data = '0;
      @(negedge clk_i);
      init_req = 1'b1; init_seed = seed; mem_gnt = 1'b0;
      @(posedge clk_i);
      for (int i = 0; i < 400 && !fin; i++) begin
         @(negedge clk_i);
         abort = 1'b0;
         if (i == 0) begin
            chk("seed_no_req", 64'(mem_req), 64'd0);
            chk("seed_busy", 64'(busy), 64'd1);
         end
         if (hold_cyc == 0) init_req = 1'b0;
         if (ab_done) begin
            ab_post++;
            if (ab_post == 1) begin
               chk("abort_req_low", 64'(mem_req), 64'd0);
               chk("abort_busy_low", 64'(busy), 64'd0);
               chk("abort_lfsr_cleared", dut.lfsr_state, DEF_SEED);
            end
            if (ab_post > 4) fin = 1;
         end
         if (n_ack > 0) begin
            post++;
            chk("post_ack_idle", 64'(busy | mem_req), 64'd0);
            if (post > hold_cyc) init_req = 1'b0;
            if (post > hold_cyc + 3) fin = 1;
         end
         g = 1'b0;
         if (mem_req) begin
            chk("we_eq_req", 64'(mem_we), 64'd1);
            if (p_req && !p_gnt) begin
               chk("hold_addr", 64'(mem_addr), 64'(p_addr));
               chk("hold_data", 64'(mem_wdata), 64'(p_data));
            end
            case (gmode)
               1:       g = 1'b1;
               3:       g = (req_cyc % 3 == 2);
               default: g = 1'($urandom_range(0, 1));
            endcase
            if (g) begin
               chk("wr_addr", 64'(mem_addr), 64'(n_wr));
               chk("wr_data", 64'(mem_wdata), m & DMASK);
               if (n_wr == 0) first_dat = 64'(mem_wdata);
               m = ref_step(m);
               if (n_wr == abort_wr) begin
                  abort = 1'b1;
                  ab_done = 1;
               end
               n_wr++;
            end
            req_cyc++;
         end
         p_req = mem_req; p_gnt = g; p_addr = mem_addr; p_data = mem_wdata;
         mem_gnt = g;
         if (ack) begin
            n_ack++;
            if (ack_edge < 0) ack_edge = cyc + 1;
         end
         @(posedge clk_i);
         cyc++;
      end
      chk("run_terminated", 64'(fin), 64'd1);
      @(negedge clk_i);
      mem_gnt = 1'b0; abort = 1'b0; init_req = 1'b0;
   endtask

   initial begin
      int          nw, na, ae;
      logic [63:0] fd;
      bit          found;
      repeat (3) @(negedge clk_i);
      chk("rst_req", 64'(mem_req), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_lfsr", dut.lfsr_state, DEF_SEED);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("idle_busy", 64'(busy), 64'd0);

      // seed 1, grant tied high
      run_init(64'd1, 1, -1, 0, nw, na, ae, fd);
      chk("s1_writes", 64'(nw), 64'(DEPTH));
      chk("s1_acks", 64'(na), 64'd1);
      chk("s1_ack_edge", 64'(ae), 64'(DEPTH + 2));
      chk("s1_first_dat", fd, 64'h2);

      // random seed, grant every third cycle
      run_init({$urandom, $urandom}, 3, -1, 0, nw, na, ae, fd);
      chk("g3_writes", 64'(nw), 64'(DEPTH));
      chk("g3_acks", 64'(na), 64'd1);

      // zero seed falls back to the default seed
      run_init(64'd0, 1, -1, 0, nw, na, ae, fd);
      chk("s0_writes", 64'(nw), 64'(DEPTH));
      chk("s0_ack_edge", 64'(ae), 64'(DEPTH + 2));
      chk("s0_first_dat", fd, ref_step(DEF_SEED) & DMASK);

      // abort together with the grant of the 5th write
      run_init({$urandom, $urandom}, 0, 4, 0, nw, na, ae, fd);
      chk("ab_writes", 64'(nw), 64'd5);
      chk("ab_no_ack", 64'(na), 64'd0);

      // restart after abort begins again at address 0
      run_init({$urandom, $urandom}, 0, -1, 0, nw, na, ae, fd);
      chk("restart_writes", 64'(nw), 64'(DEPTH));
      chk("restart_acks", 64'(na), 64'd1);

      // request held high 40 cycles after ack
      run_init({$urandom, $urandom}, 1, -1, 40, nw, na, ae, fd);
      chk("hold_writes", 64'(nw), 64'(DEPTH));
      chk("hold_single_ack", 64'(na), 64'd1);

      // abort held: request is ignored
      @(negedge clk_i);
      abort = 1'b1; init_req = 1'b1; init_seed = {$urandom, $urandom};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         chk("abort_hold_idle", 64'(busy | mem_req), 64'd0);
      end
      abort = 1'b0; init_req = 1'b0;
      repeat (2) @(negedge clk_i);

      for (int r = 0; r < 4; r++) begin
         logic [63:0] sd;
         sd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
         run_init(sd, ($urandom_range(0, 1) == 0) ? 0 : 3, -1, 0, nw, na, ae, fd);
         chk("rnd_writes", 64'(nw), 64'(DEPTH));
         chk("rnd_acks", 64'(na), 64'd1);
      end

      // reset asserted mid-Write at address 7
      @(negedge clk_i);
      init_req = 1'b1; init_seed = {$urandom, $urandom}; mem_gnt = 1'b1;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk_i);
         init_req = 1'b0;
         if (mem_req && mem_addr == AW'(7)) found = 1;
      end
      chk("rst_reach_addr7", 64'(found), 64'd1);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_req", 64'(mem_req), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_addr", 64'(mem_addr), 64'd0);
      chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
      mem_gnt = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("post_rst_lfsr", dut.lfsr_state, DEF_SEED);
      na = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (ack) na++;
         if (busy) na++;
      end
      chk("post_rst_quiet", 64'(na), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
